// File: rtl/aes_inv_cipher_iter_if.sv
// Request/response and key-RAM bundle for the iterative AES decryptor.
// The core sits on the slave side; the controller or key RAM drives the master side.
interface aes_inv_cipher_iter_if;
  logic         start;
  logic [3:0]   nr;
  logic [127:0] ciphertext;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic [127:0] plaintext;
  logic         busy;
  logic         done;
  logic         err;

  modport slave (
    input  start, nr, ciphertext, rk_data,
    output rk_idx, plaintext, busy, done, err
  );

  modport master (
    output start, nr, ciphertext, rk_data,
    input  rk_idx, plaintext, busy, done, err
  );
endinterface

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128/192/256 inverse cipher, one round per clock.
// Round keys are fetched from an external key RAM with a registered read.
module aes_inv_cipher_iter #(
  parameter int RK_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  aes_inv_cipher_iter_if.slave bus
);

  localparam logic [3:0] PREFETCH = 4'(RK_LAT);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ADD0, S_ROUND, S_FINAL} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] b;
    logic [7:0] sq;
    logic [7:0] acc;
    b   = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    // b^254 = b^2*b^4*...*b^128 is the field inverse, with 0 mapping to 0
    sq  = gf_mul(b, b);
    acc = sq;
    for (int k = 0; k < 6; k++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    for (int k = 0; k < 4; k++) begin
      a[k]  = c[31-8*k -: 8];
      x2    = xtime(a[k]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[k] = x8 ^ a[k];
      mb[k] = x8 ^ x2 ^ a[k];
      md[k] = x8 ^ x4 ^ a[k];
      me[k] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  state_t       state_q;
  logic [3:0]   nr_q;
  logic [3:0]   ctr_q;
  logic [3:0]   rk_idx_q;
  logic [127:0] blk_q;
  logic [127:0] pt_q;
  logic         busy_q;
  logic         done_q;
  logic         err_q;

  logic [127:0] isb_w;
  logic [127:0] ark_w;
  logic [127:0] imc_w;
  logic [3:0]   rk_idx_dec;
  logic         nr_ok;

  // Byte i sits at row i%4, column i/4; InvShiftRows pulls row r from column c-r
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_byte
      localparam int SRC = (gi % 4) + 4 * (((gi / 4) - (gi % 4) + 4) % 4);
      assign isb_w[127-8*gi -: 8] = inv_sbox(blk_q[127-8*SRC -: 8]);
    end
    for (gi = 0; gi < 4; gi++) begin : g_col
      assign imc_w[127-32*gi -: 32] = inv_mix_col(ark_w[127-32*gi -: 32]);
    end
  endgenerate

  assign ark_w      = isb_w ^ bus.rk_data;
  assign rk_idx_dec = (rk_idx_q == 4'd0) ? 4'd0 : rk_idx_q - 4'd1;
  assign nr_ok      = (bus.nr == 4'd10) || (bus.nr == 4'd12) || (bus.nr == 4'd14);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      nr_q     <= 4'd0;
      ctr_q    <= 4'd0;
      rk_idx_q <= 4'd0;
      blk_q    <= 128'd0;
      pt_q     <= 128'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            if (nr_ok) begin
              blk_q    <= bus.ciphertext;
              nr_q     <= bus.nr;
              rk_idx_q <= bus.nr;
              busy_q   <= 1'b1;
              state_q  <= S_WAIT;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          rk_idx_q <= nr_q - PREFETCH;
          state_q  <= S_ADD0;
        end
        S_ADD0: begin
          blk_q    <= blk_q ^ bus.rk_data;
          rk_idx_q <= rk_idx_dec;
          ctr_q    <= nr_q - 4'd1;
          state_q  <= S_ROUND;
        end
        S_ROUND: begin
          blk_q    <= imc_w;
          rk_idx_q <= rk_idx_dec;
          ctr_q    <= ctr_q - 4'd1;
          if (ctr_q == 4'd1) state_q <= S_FINAL;
        end
        S_FINAL: begin
          pt_q     <= ark_w;
          rk_idx_q <= rk_idx_dec;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.rk_idx    = rk_idx_q;
  assign bus.plaintext = pt_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule
